// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detector: load-use and branch-operand stalls, memory freeze,
// stall-cycle counter and sticky memory-timeout flag.
module hazard_stall_unit #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_UsesRt,
    input  logic             ID_Branch,
    input  logic             BranchTaken,
    input  logic             EX_MemRead,
    input  logic             EX_RegisterWrite,
    input  logic [4:0]       EX_WriteRegister,
    input  logic             MEM_MemRead,
    input  logic [4:0]       MEM_WriteRegister,
    input  logic             MEM_Access,
    input  logic             DMem_Ready,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IDEX_Bubble,
    output logic             IF_Flush,
    output logic             Freeze,
    output logic [CNT_W-1:0] StallCycles,
    output logic             Timeout
);

    typedef enum logic {RUN, STALL} stateT;

    stateT             state, stateNext;
    logic              rem, remNext;
    logic [WAIT_W-1:0] wcnt, wcntInc;
    logic              matchEx, matchMem;
    logic [1:0]        hz;

    assign matchEx = (EX_WriteRegister != 5'd0) &&
                     ((EX_WriteRegister == ID_rs) ||
                      (ID_UsesRt && (EX_WriteRegister == ID_rt)));

    assign matchMem = (MEM_WriteRegister != 5'd0) &&
                      ((MEM_WriteRegister == ID_rs) ||
                       (ID_UsesRt && (MEM_WriteRegister == ID_rt)));

    // A branch on a load result waits for the load to reach WB.
    always_comb begin
        hz = 2'd0;
        if (ID_Branch && EX_MemRead && matchEx) begin
            hz = 2'd2;
        end else if ((EX_MemRead && matchEx) ||
                     (ID_Branch && EX_RegisterWrite && matchEx) ||
                     (ID_Branch && MEM_MemRead && matchMem)) begin
            hz = 2'd1;
        end
    end

    assign Freeze  = MEM_Access & ~DMem_Ready;
    assign wcntInc = (wcnt == '1) ? wcnt : wcnt + 1'b1;

    always_comb begin
        stateNext   = state;
        remNext     = rem;
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IDEX_Bubble = 1'b0;
        IF_Flush    = 1'b0;
        if (Freeze) begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
        end else if (state == STALL) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
            remNext     = rem - 1'b1;
            if (rem == 1'b1) begin
                stateNext = RUN;
            end
        end else if (hz != 2'd0) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
            if (hz == 2'd2) begin
                stateNext = STALL;
                remNext   = 1'b1;
            end
        end else begin
            IF_Flush = ID_Branch & BranchTaken;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            rem         <= 1'b0;
            wcnt        <= '0;
            StallCycles <= '0;
            Timeout     <= 1'b0;
        end else begin
            state <= stateNext;
            rem   <= remNext;
            if (Freeze) begin
                wcnt <= wcntInc;
                if (wcntInc == WAIT_W'(MAX_WAIT)) begin
                    Timeout <= 1'b1;
                end
            end else begin
                wcnt <= '0;
            end
            if (!PC_Write && (StallCycles != '1)) begin
                StallCycles <= StallCycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: per-cycle expected outputs are
// queued with the stimulus and checked at the following falling edge.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  idRs, idRt, exWr, memWr;
    logic        idUsesRt, idBranch, brTaken;
    logic        exMemRead, exRegWrite, memMemRead, memAccess, dmemReady;
    logic        pcWrite, ifidWrite, idexBubble, ifFlush, freeze, timeout;
    logic [15:0] stallCycles;

    typedef struct {
        string       tag;
        logic [21:0] v;
    } expT;

    expT         sb[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] expStall = 16'd0;
    logic        expTo = 1'b0;
    int          wcModel = 0;

    always #5 clk = ~clk;

    hazard_stall_unit dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ID_rs            (idRs),
        .ID_rt            (idRt),
        .ID_UsesRt        (idUsesRt),
        .ID_Branch        (idBranch),
        .BranchTaken      (brTaken),
        .EX_MemRead       (exMemRead),
        .EX_RegisterWrite (exRegWrite),
        .EX_WriteRegister (exWr),
        .MEM_MemRead      (memMemRead),
        .MEM_WriteRegister(memWr),
        .MEM_Access       (memAccess),
        .DMem_Ready       (dmemReady),
        .PC_Write         (pcWrite),
        .IFID_Write       (ifidWrite),
        .IDEX_Bubble      (idexBubble),
        .IF_Flush         (ifFlush),
        .Freeze           (freeze),
        .StallCycles      (stallCycles),
        .Timeout          (timeout)
    );

    task automatic idle();
        idRs = 5'd0; idRt = 5'd0; idUsesRt = 1'b0;
        idBranch = 1'b0; brTaken = 1'b0;
        exMemRead = 1'b0; exRegWrite = 1'b0; exWr = 5'd0;
        memMemRead = 1'b0; memWr = 5'd0;
        memAccess = 1'b0; dmemReady = 1'b1;
    endtask

    // Queue this cycle's expected outputs, then advance one clock and
    // update the bench's own counter/timeout model.
    task automatic step(input string tag, input logic pc, input logic ifid,
                        input logic bub, input logic fl, input logic fz);
        expT e;
        e.tag = tag;
        e.v   = {pc, ifid, bub, fl, fz, expTo, expStall};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!pc && expStall != 16'hffff) expStall++;
        if (fz) begin
            if (wcModel != 15) wcModel++;
            if (wcModel == 15) expTo = 1'b1;
        end else begin
            wcModel = 0;
        end
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        #3;
        total++;
        if ({pcWrite, ifidWrite, idexBubble, ifFlush, freeze} !== 5'b11000) begin
            bad++;
            $display("FAIL reset_outs got=%b want=11000",
                     {pcWrite, ifidWrite, idexBubble, ifFlush, freeze});
        end
        total++;
        if ({timeout, stallCycles} !== 17'd0) begin
            bad++;
            $display("FAIL reset_regs got=%h want=0", {timeout, stallCycles});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step("idle", 1, 1, 0, 0, 0);
    endtask

    task automatic test_load_use();
        exMemRead = 1'b1; exWr = 5'd8; idRs = 5'd8;
        step("lu_stall", 0, 0, 1, 0, 0);
        exMemRead = 1'b0; exWr = 5'd0;
        step("lu_go", 1, 1, 0, 0, 0);
        exMemRead = 1'b1; exWr = 5'd7; idRs = 5'd3; idRt = 5'd7;
        step("lu_rt_unused", 1, 1, 0, 0, 0);
        idUsesRt = 1'b1;
        step("lu_rt_used", 0, 0, 1, 0, 0);
        idle();
        exMemRead = 1'b1; exWr = 5'd0;
        step("lu_r0", 1, 1, 0, 0, 0);
        idle();
    endtask

    task automatic test_branch_load();
        idBranch = 1'b1; brTaken = 1'b1; idRt = 5'd9; idUsesRt = 1'b1;
        exMemRead = 1'b1; exWr = 5'd9;
        step("bl_run", 0, 0, 1, 0, 0);
        exMemRead = 1'b0; exWr = 5'd0;
        memMemRead = 1'b1; memWr = 5'd9;
        step("bl_stall", 0, 0, 1, 0, 0);
        memMemRead = 1'b0; memWr = 5'd0;
        step("bl_flush", 1, 1, 0, 1, 0);
        idle();
        step("bl_after", 1, 1, 0, 0, 0);
    endtask

    task automatic test_branch_alu();
        idBranch = 1'b1; exRegWrite = 1'b1; exWr = 5'd5; idRs = 5'd5;
        step("ba_stall", 0, 0, 1, 0, 0);
        exRegWrite = 1'b0; exWr = 5'd0;
        step("ba_go", 1, 1, 0, 0, 0);
        exRegWrite = 1'b1; exWr = 5'd0; idRs = 5'd0; brTaken = 1'b1;
        step("ba_r0", 1, 1, 0, 1, 0);
        idle();
        idBranch = 1'b1; memMemRead = 1'b1; memWr = 5'd4;
        idRt = 5'd4; idUsesRt = 1'b1;
        step("ba_memld", 0, 0, 1, 0, 0);
        idle();
        exRegWrite = 1'b1; exWr = 5'd6; idRs = 5'd6;
        step("alu_fwd", 1, 1, 0, 0, 0);
        idle();
    endtask

    task automatic test_freeze_stall();
        idBranch = 1'b1; idRs = 5'd12; exMemRead = 1'b1; exWr = 5'd12;
        step("fs_enter", 0, 0, 1, 0, 0);
        idle();
        idBranch = 1'b1; memAccess = 1'b1; dmemReady = 1'b0;
        for (int i = 0; i < 3; i++) step("fs_frz", 0, 0, 0, 0, 1);
        dmemReady = 1'b1;
        step("fs_resume", 0, 0, 1, 0, 0);
        memAccess = 1'b0;
        step("fs_run", 1, 1, 0, 0, 0);
        idle();
        exMemRead = 1'b1; exWr = 5'd3; idRs = 5'd3;
        memAccess = 1'b1; dmemReady = 1'b0;
        step("fs_prio", 0, 0, 0, 0, 1);
        idle();
        step("fs_idle", 1, 1, 0, 0, 0);
    endtask

    task automatic test_timeout();
        memAccess = 1'b1; dmemReady = 1'b0;
        for (int i = 0; i < 16; i++) step("to_frz", 0, 0, 0, 0, 1);
        idle();
        step("to_sticky", 1, 1, 0, 0, 0);
        total++;
        if (timeout !== 1'b1) begin
            bad++;
            $display("FAIL to_hold got=%b want=1", timeout);
        end
    endtask

    task automatic test_async_reset();
        idBranch = 1'b1; idRs = 5'd10; exMemRead = 1'b1; exWr = 5'd10;
        step("ar_enter", 0, 0, 1, 0, 0);
        idle();
        #2;
        total++;
        if ({pcWrite, idexBubble} !== 2'b01) begin
            bad++;
            $display("FAIL ar_install got=%b want=01", {pcWrite, idexBubble});
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({pcWrite, idexBubble, timeout, stallCycles} !== {2'b10, 17'd0}) begin
            bad++;
            $display("FAIL ar_async got=%h want=%h",
                     {pcWrite, idexBubble, timeout, stallCycles}, {2'b10, 17'd0});
        end
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        expStall = 16'd0; expTo = 1'b0; wcModel = 0;
        step("ar_idle", 1, 1, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (sb.size() > 0) begin
                    expT e;
                    logic [21:0] act;
                    e   = sb.pop_front();
                    act = {pcWrite, ifidWrite, idexBubble, ifFlush, freeze,
                           timeout, stallCycles};
                    total++;
                    if (act !== e.v) begin
                        bad++;
                        $display("FAIL %s got=%h want=%h", e.tag, act, e.v);
                    end
                end
            end
        join_none
        test_reset();
        test_load_use();
        test_branch_load();
        test_branch_alu();
        test_freeze_stall();
        test_timeout();
        test_async_reset();
        repeat (2) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
